spi_master_ctrl: RTL and testbench
==================================

# spi_master_ctrl

Transaction controller for a master-side SPI link. It latches a word, a slave index and a mode, then generates SCLK from `clk` through a programmable divider. It drives one-hot slave select, shifts the word out MSB-first while shifting the slave's reply in, and reports completion to the CPU-side logic. It sits between the register interface and the external SPI pins, and it sequences the shift datapath that a plain SPI shift register leaves to software.

## Interface
- `word_width`, 8, bits per transfer (≥2)
- `SS_width`, 4, number of slave-select lines (≥2)
- `div_width`, 8, width of the clock divider value
- `clk` input 1: the single clock; all state updates on posedge
- `rst` input 1: synchronous, active-high reset
- `start` input 1: request a transfer; sampled only in IDLE
- `ss_sel` input max($clog2(SS_width),1): slave index, latched at accept
- `cpol` input 1: SCLK idle level, latched at accept
- `cpha` input 1: 0 = sample on leading edge, 1 = sample on trailing edge; latched at accept
- `div` input div_width: half-period = div+1 clk cycles; latched at accept
- `tx_data` input word_width: word to send; latched at accept
- `rx_data` output word_width: last received word
- `busy` output 1: high in SETUP, XFER and HOLD
- `done` output 1: one-cycle completion pulse
- `SCLK` output 1: serial clock
- `MOSI` output 1: serial data out (tx shift register MSB)
- `MISO` input 1: serial data in
- `SS_OUT` output SS_width: one-hot, active-high slave select

## Operation
- Reset values:
  - FSM = IDLE.
  - SCLK=0, MOSI=0, SS_OUT=0, rx_data=0, busy=0, done=0.
  - Latched cpol=0, cpha=0, div=0.
- FSM states: IDLE, SETUP, XFER, HOLD.
- IDLE → SETUP when `start`=1:
  - Latch cpol, cpha, div and ss_sel.
  - Load tx_data into the tx shift register; clear the rx shift register.
  - Clear the half-period counter and the edge counter.
- SETUP: SS_OUT = 1<<ss_sel. SCLK = latched cpol. MOSI = tx MSB. Lasts one half-period, then → XFER.
- XFER: each half-period expiry toggles SCLK and increments the edge index e (1..2·word_width). Odd e is a leading edge, even e is a trailing edge.
  - cpha=0: on odd e, sample MISO into the rx LSB (shift left). On even e, shift tx left.
  - cpha=1: on odd e≥3, shift tx left. On even e, sample MISO into the rx LSB.
  - After e=2·word_width, → HOLD. SCLK is back at cpol.
- HOLD: SS_OUT is held and SCLK = cpol for one half-period, then → IDLE.
- On that same transition:
  - rx_data ← rx shift register.
  - done=1 for exactly the first IDLE cycle.
  - SS_OUT ← 0.
- In IDLE, SCLK = latched cpol from the last transfer. MOSI holds its last value.
- `start` while busy=1 is ignored and not queued.
- `start`=1 in the done cycle is accepted, because busy=0 there. This gives back-to-back transfers with exactly one IDLE cycle between them.
- Input changes on cpol, cpha, div, ss_sel and tx_data during busy have no effect.
- `rst` at any point, including mid-XFER, forces the reset values on the next edge. No done pulse is issued and rx_data is cleared.
- `rst` and `start` asserted together: reset wins.

## Timing
- Half-period = div+1 cycles; div=0 toggles SCLK every clk cycle.
- Accept at edge k: SETUP visible after edge k, and SS_OUT and busy go high at the same time.
- A transfer lasts (2·word_width+2)·(div+1) cycles from accept to the done cycle.
  - word_width=8, div=0: done is high in cycle k+18.
  - word_width=8, div=3: done is high in cycle k+72.
- SCLK, MOSI and SS_OUT are registered outputs: no combinational path from any input.
- The divider counter wraps at div and never overflows div_width. div = 2^div_width−1 is legal.

## Structure
- Shared package: `SPI_MASTER_STATE` enum {IDLE, SETUP, XFER, HOLD} and the `max` helper already in utils.
- One sub-module: `spi_clk_div`, which takes clk, rst, clear and div, and outputs a one-cycle `tick` at each half-period expiry.
- Slave-select decode reuses the existing `decoder_c` (enable = busy).
- FSM, edge counter and shift registers stay in `spi_master_ctrl`.

## Test plan
- Mode 0, div=0, tx_data=0xA5, ss_sel=2, MISO looped to MOSI:
  - SS_OUT=4'b0100 throughout.
  - 16 SCLK toggles starting low.
  - done at k+18; rx_data=0xA5.
- Mode 3 (cpol=1, cpha=1), div=3, tx_data=0x3C, MISO driven by a slave model returning 0xC3:
  - SCLK idles high.
  - Each level lasts 4 cycles.
  - rx_data=0xC3; done at k+72.
- `start` pulsed at k+5 during a busy transfer: ignored, only one done pulse.
- `start` held continuously:
  - Second accept in the done cycle.
  - Second SETUP begins the following cycle.
- `rst` asserted at k+9 of a mode-0, div=0 transfer:
  - Next cycle: SS_OUT=0, SCLK=0, busy=0, rx_data=0.
  - No done pulse.
- Mode 1 (cpha=1), div=1, tx_data=0x81:
  - MOSI holds 1 from SETUP through edge 2.
  - MOSI changes only on odd edges ≥3.

Source files
------------

// File: rtl/spi_master_ctrl_pkg.sv
// Shared types and helpers for the SPI master transaction controller.
// Imported by the controller, its clock divider and the select decoder.
package spi_master_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD
  } SPI_MASTER_STATE;

  function automatic int max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/decoder_c.sv
// Binary-to-one-hot decoder with enable.
// Out-of-range indices decode to all zeros.
module decoder_c #(
  parameter int OUT_W = 4,
  parameter int IN_W  = 2
) (
  input  logic            en_i,
  input  logic [IN_W-1:0] sel_i,
  output logic [OUT_W-1:0] dec_o
);

  always_comb begin
    dec_o = '0;
    if (en_i) begin
      dec_o = OUT_W'(1) << sel_i;
    end
  end

endmodule

// File: rtl/spi_clk_div.sv
// Half-period divider: pulses tick once every div+1 clk cycles.
// clear restarts the count so the first half-period is a full one.
module spi_clk_div #(
  parameter int div_width = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic [div_width-1:0] div,
  output logic                 tick
);

  logic [div_width-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == div);

  // wraps at div, so div = all-ones never overflows
  always_comb begin
    cnt_d = cnt_q + div_width'(1);
    if (tick || clear) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master transaction controller: latches a request, runs SETUP/XFER/HOLD,
// shifts MSB-first and reports a one-cycle done pulse back in IDLE.
module spi_master_ctrl
  import spi_master_ctrl_pkg::*;
#(
  parameter int word_width = 8,
  parameter int SS_width   = 4,
  parameter int div_width  = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [max($clog2(SS_width), 1)-1:0]  ss_sel,
  input  logic                                 cpol,
  input  logic                                 cpha,
  input  logic [div_width-1:0]                 div,
  input  logic [word_width-1:0]                tx_data,
  output logic [word_width-1:0]                rx_data,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 SCLK,
  output logic                                 MOSI,
  input  logic                                 MISO,
  output logic [SS_width-1:0]                  SS_OUT
);

  localparam int SSW = max($clog2(SS_width), 1);
  localparam int EW  = $clog2(2 * word_width + 1);
  localparam logic [EW-1:0] LAST_E = EW'(2 * word_width);
  localparam logic [EW-1:0] FIRST_TX_E = EW'(3);

  SPI_MASTER_STATE state_q, state_d;

  logic                  cpol_q, cpol_d;
  logic                  cpha_q, cpha_d;
  logic [div_width-1:0]  div_q, div_d;
  logic [SSW-1:0]        sel_q, sel_d;
  logic [word_width-1:0] tx_q, tx_d;
  logic [word_width-1:0] rx_q, rx_d;
  logic [word_width-1:0] rxo_q, rxo_d;
  logic [EW-1:0]         e_q, e_d;
  logic                  sclk_q, sclk_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  clear;
  logic                  tick;

  spi_clk_div #(
    .div_width(div_width)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .div  (div_q),
    .tick (tick)
  );

  decoder_c #(
    .OUT_W(SS_width),
    .IN_W (SSW)
  ) u_ss (
    .en_i (busy_q),
    .sel_i(sel_q),
    .dec_o(SS_OUT)
  );

  always_comb begin
    state_d = state_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    div_d   = div_q;
    sel_d   = sel_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rxo_d   = rxo_q;
    e_d     = e_q;
    sclk_d  = sclk_q;
    done_d  = 1'b0;
    clear   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          cpol_d  = cpol;
          cpha_d  = cpha;
          div_d   = div;
          sel_d   = ss_sel;
          tx_d    = tx_data;
          rx_d    = '0;
          e_d     = '0;
          sclk_d  = cpol;
          clear   = 1'b1;
        end
      end
      SETUP: begin
        if (tick) begin
          state_d = XFER;
        end
      end
      XFER: begin
        if (tick) begin
          e_d    = e_q + EW'(1);
          sclk_d = ~sclk_q;
          // odd index = leading edge, even = trailing edge
          if (e_d[0]) begin
            if (!cpha_q) begin
              rx_d = {rx_q[word_width-2:0], MISO};
            end else if (e_d >= FIRST_TX_E) begin
              tx_d = tx_q << 1;
            end
          end else begin
            if (!cpha_q) begin
              tx_d = tx_q << 1;
            end else begin
              rx_d = {rx_q[word_width-2:0], MISO};
            end
          end
          if (e_d == LAST_E) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_d = IDLE;
          rxo_d   = rx_q;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      div_q   <= '0;
      sel_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rxo_q   <= '0;
      e_q     <= '0;
      sclk_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      div_q   <= div_d;
      sel_q   <= sel_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rxo_q   <= rxo_d;
      e_q     <= e_d;
      sclk_q  <= sclk_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign rx_data = rxo_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign SCLK    = sclk_q;
  assign MOSI    = tx_q[word_width-1];

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: table of transfers plus
// hand sequences for busy-start, held start and mid-transfer reset.
module tb_spi_master_ctrl;

  typedef struct {
    bit       cpol;
    bit       cpha;
    bit       loop;
    bit [7:0] dv;
    bit [1:0] ss;
    bit [7:0] tx;
    bit [7:0] sw;
    bit [7:0] rx;
    bit [3:0] ss_exp;
    int       done_at;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] ss_sel = '0;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic [7:0] div_v = '0;
  logic [7:0] tx_data = '0;
  logic [7:0] rx_data;
  logic       busy;
  logic       done;
  logic       sclk;
  logic       mosi;
  logic       miso_s = 1'b0;
  logic       loop = 1'b0;
  logic       miso_w;
  logic [3:0] ss_out;

  int checks = 0;
  int failures = 0;

  // results of the last run_xfer
  int       r_done_at, r_done_cnt, r_tog, r_first, r_int_bad;
  int       r_ss_bad, r_mosi_bad, r_mosi_chg;
  logic     r_sclk0, r_msb_ok;
  logic [7:0] r_srx;
  logic [3:0] pr_ss;
  logic     pr_sclk, pr_busy, pr_done;
  logic [7:0] pr_rx;

  vec_t tbl[5];

  assign miso_w = loop ? mosi : miso_s;

  spi_master_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .ss_sel (ss_sel),
    .cpol   (cpol),
    .cpha   (cpha),
    .div    (div_v),
    .tx_data(tx_data),
    .rx_data(rx_data),
    .busy   (busy),
    .done   (done),
    .SCLK   (sclk),
    .MOSI   (mosi),
    .MISO   (miso_w),
    .SS_OUT (ss_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit shift_edge(input int ed, input bit ph);
    if (!ph) return (ed % 2) == 0;
    return ((ed % 2) == 1) && (ed >= 3);
  endfunction

  // Accepts one transfer, then observes ncyc cycles (n=0 is first SETUP cycle).
  task automatic run_xfer(input vec_t v, input int extra_at,
                          input int rst_at, input int ncyc);
    logic ps, pm;
    bit   tog;
    int   ed, last;
    @(negedge clk);
    cpol = v.cpol; cpha = v.cpha; div_v = v.dv; ss_sel = v.ss;
    tx_data = v.tx; loop = v.loop; miso_s = v.sw[7]; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cpol = ~v.cpol; cpha = ~v.cpha; div_v = v.dv + 8'd1;
    ss_sel = v.ss + 2'd1; tx_data = ~v.tx;
    r_done_at = -1; r_done_cnt = 0; r_tog = 0; r_first = -1;
    r_int_bad = 0; r_ss_bad = 0; r_mosi_bad = 0; r_mosi_chg = 0;
    r_msb_ok = 1'b1; r_srx = '0; r_sclk0 = sclk;
    ps = sclk; pm = mosi; ed = 0; last = 0;
    for (int n = 0; n < ncyc; n++) begin
      if (n > 0) @(negedge clk);
      tog = (sclk !== ps);
      if (tog) begin
        ed++; r_tog++;
        if (r_first < 0) r_first = n;
        else if (n - last != int'(v.dv) + 1) r_int_bad++;
        last = n;
        if (!v.cpha) begin
          if (ed % 2 == 1) r_srx = {r_srx[6:0], mosi};
          else if (ed < 16) miso_s = v.sw[7 - ed / 2];
        end else begin
          if (ed % 2 == 1) miso_s = v.sw[7 - (ed - 1) / 2];
          else r_srx = {r_srx[6:0], mosi};
        end
      end
      if (n > 0 && mosi !== pm) begin
        r_mosi_chg++;
        if (!(tog && shift_edge(ed, v.cpha))) r_mosi_bad++;
      end
      if (busy && ed <= 2 && mosi !== v.tx[7]) r_msb_ok = 1'b0;
      if (busy && ss_out !== v.ss_exp) r_ss_bad++;
      if (!busy && ss_out !== 4'b0) r_ss_bad++;
      if (done === 1'b1) begin
        r_done_cnt++;
        if (r_done_at < 0) r_done_at = n;
      end
      if (n == rst_at + 1) begin
        pr_ss = ss_out; pr_sclk = sclk; pr_busy = busy;
        pr_rx = rx_data; pr_done = done;
      end
      ps = sclk; pm = mosi;
      start = (n == extra_at);
      if (n == rst_at) rst = 1'b1;
      if (n == rst_at + 1) rst = 1'b0;
    end
    start = 1'b0;
  endtask

  initial begin
    int ss_bad;
    tbl[0] = '{1'b0, 1'b0, 1'b1, 8'd0,   2'd2, 8'hA5, 8'h00, 8'hA5, 4'b0100, 18};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 8'd3,   2'd1, 8'h3C, 8'hC3, 8'hC3, 4'b0010, 72};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 8'd1,   2'd0, 8'h81, 8'h5A, 8'h5A, 4'b0001, 36};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 8'd2,   2'd3, 8'h0F, 8'hF0, 8'hF0, 4'b1000, 54};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 8'd255, 2'd1, 8'h55, 8'hAA, 8'hAA, 4'b0010, 4608};

    // reset held together with start: reset wins
    start = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_sclk", {31'b0, sclk}, 32'd0);
    chk("rst_mosi", {31'b0, mosi}, 32'd0);
    chk("rst_ss", {28'b0, ss_out}, 32'd0);
    chk("rst_rx", {24'b0, rx_data}, 32'd0);
    rst = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_xfer(tbl[i], -1, -1000, tbl[i].done_at + 4);
      chk($sformatf("v%0d_sclk0", i), {31'b0, r_sclk0}, {31'b0, tbl[i].cpol});
      chk($sformatf("v%0d_done_at", i), r_done_at, tbl[i].done_at);
      chk($sformatf("v%0d_done_cnt", i), r_done_cnt, 1);
      chk($sformatf("v%0d_toggles", i), r_tog, 16);
      chk($sformatf("v%0d_first_tog", i), r_first, 2 * (int'(tbl[i].dv) + 1));
      chk($sformatf("v%0d_halfper", i), r_int_bad, 0);
      chk($sformatf("v%0d_ss", i), r_ss_bad, 0);
      chk($sformatf("v%0d_mosi_edge", i), r_mosi_bad, 0);
      chk($sformatf("v%0d_slave_rx", i), {24'b0, r_srx}, {24'b0, tbl[i].tx});
      chk($sformatf("v%0d_rx", i), {24'b0, rx_data}, {24'b0, tbl[i].rx});
      chk($sformatf("v%0d_idle_sclk", i), {31'b0, sclk}, {31'b0, tbl[i].cpol});
    end

    // mode 1, 0x81: MSB held through edge 2, MOSI moves only at edges 3 and 15
    run_xfer(tbl[2], -1, -1000, 40);
    chk("m1_msb_hold", {31'b0, r_msb_ok}, 32'd1);
    chk("m1_mosi_chg", r_mosi_chg, 2);
    chk("m1_mosi_edge", r_mosi_bad, 0);

    // start pulse during busy is ignored
    run_xfer(tbl[0], 5, -1000, 60);
    chk("busy_start_done_cnt", r_done_cnt, 1);
    chk("busy_start_done_at", r_done_at, 18);
    chk("busy_start_toggles", r_tog, 16);
    chk("busy_start_rx", {24'b0, rx_data}, 32'hA5);

    // reset in cycle k+9 of a mode-0 transfer
    run_xfer(tbl[0], -1, 9, 40);
    chk("midrst_ss", {28'b0, pr_ss}, 32'd0);
    chk("midrst_sclk", {31'b0, pr_sclk}, 32'd0);
    chk("midrst_busy", {31'b0, pr_busy}, 32'd0);
    chk("midrst_rx", {24'b0, pr_rx}, 32'd0);
    chk("midrst_no_done", r_done_cnt, 0);

    // start held: second accept in the done cycle
    @(negedge clk);
    cpol = 1'b0; cpha = 1'b0; div_v = 8'd0; ss_sel = 2'd1;
    tx_data = 8'h3C; loop = 1'b1; start = 1'b1;
    @(negedge clk);
    ss_sel = 2'd3; tx_data = 8'hC3;
    ss_bad = 0;
    for (int n = 0; n < 40; n++) begin
      if (n > 0) @(negedge clk);
      if (n < 18 && ss_out !== 4'b0010) ss_bad++;
      if (n == 18) begin
        chk("held_done1", {31'b0, done}, 32'd1);
        chk("held_busy_gap", {31'b0, busy}, 32'd0);
        chk("held_rx1", {24'b0, rx_data}, 32'h3C);
      end
      if (n == 19) begin
        chk("held_busy2", {31'b0, busy}, 32'd1);
        chk("held_ss2", {28'b0, ss_out}, 32'b1000);
        chk("held_done_width", {31'b0, done}, 32'd0);
        start = 1'b0;
      end
      if (n == 37) begin
        chk("held_done2", {31'b0, done}, 32'd1);
        chk("held_rx2", {24'b0, rx_data}, 32'hC3);
      end
    end
    chk("held_ss1", ss_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
